// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: request/response data memory for the RISC datapath.
//
// A parametrised word array with byte-lane write strobes and registered reads.
// Every accepted request gets exactly one single-cycle response, one cycle after
// it is accepted. Addresses whose bits above the word index are non-zero are
// rejected with rsp_err and leave the array untouched. With CLEAR_ON_RESET set,
// the block zeroes the whole array after reset (one word per cycle) before it
// accepts requests.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  request present
//   req_ready  request can be accepted this cycle
//   req_write  1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_wstrb  byte-lane enables (bit i covers bits 8i+7..8i)
//   rsp_valid  one-cycle response pulse
//   rsp_rdata  read data, 0 for writes, errors and idle cycles
//   rsp_err    address out of range, qualified by rsp_valid
//   busy       clear sweep in progress
module data_memory_ctrl #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DEPTH          = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned NumLanes = DATA_W / 8;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic                accept;
  logic                in_range;
  logic [IdxW-1:0]     idx;

  logic                mem_we;
  logic [IdxW-1:0]     mem_idx;
  logic [NumLanes-1:0] mem_be;
  logic [DATA_W-1:0]   mem_wdata;

  assign idx       = req_addr[IdxW-1:0];
  // When DEPTH spans the full address space the shift leaves zero: always in range.
  assign in_range  = ((req_addr >> IdxW) == '0);
  // Nothing is accepted while reset is asserted, so an in-flight request gets no response.
  assign req_ready = (state_q == StIdle) && rst_n;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q == StClear);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_idx   = idx;
    mem_be    = '0;
    mem_wdata = '0;
    unique case (state_q)
      StClear: begin
        mem_we  = 1'b1;
        mem_idx = cnt_q;
        mem_be  = '1;
        cnt_d   = cnt_q + IdxW'(1);
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (accept && in_range && req_write) begin
          mem_we    = 1'b1;
          mem_be    = req_wstrb;
          mem_wdata = req_wdata;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!rst_n) begin
      mem_we = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && !in_range;
    rsp_rdata_d = '0;
    if (accept && in_range && !req_write) begin
      rsp_rdata_d = mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR_ON_RESET ? StClear : StIdle;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array contents are deliberately not reset; clearing is done by the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NumLanes; i++) begin
        if (mem_be[i]) begin
          mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl. Instance a uses the default
// parameters; instance b uses CLEAR_ON_RESET=0, DATA_W=32, DEPTH=16.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance a: defaults (16-bit, 8 words, clear on reset).
  logic        a_rst_n, a_req_valid, a_req_ready, a_req_write;
  logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [1:0]  a_req_wstrb;
  logic        a_rsp_valid, a_rsp_err, a_busy;

  // Instance b: 32-bit, 16 words, no clear.
  logic        b_rst_n, b_req_valid, b_req_ready, b_req_write;
  logic [15:0] b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_wstrb;
  logic        b_rsp_valid, b_rsp_err, b_busy;

  data_memory_ctrl u_dut_a (
    .clk       (clk),
    .rst_n     (a_rst_n),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_wstrb (a_req_wstrb),
    .rsp_valid (a_rsp_valid),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err),
    .busy      (a_busy)
  );

  data_memory_ctrl #(
    .DATA_W         (32),
    .ADDR_W         (16),
    .DEPTH          (16),
    .CLEAR_ON_RESET (1'b0)
  ) u_dut_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_write (b_req_write),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_wstrb (b_req_wstrb),
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err),
    .busy      (b_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance past the next rising edge; outputs are stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request to instance a for one edge, then drop req_valid.
  task automatic a_req(input logic w, input logic [15:0] addr, input logic [15:0] data,
                       input logic [1:0] strb);
    a_req_valid = 1'b1;
    a_req_write = w;
    a_req_addr  = addr;
    a_req_wdata = data;
    a_req_wstrb = strb;
    step();
    a_req_valid = 1'b0;
  endtask

  task automatic a_rsp_check(input string tag, input logic [15:0] data, input logic err);
    check_eq({tag, "_valid"}, 64'(a_rsp_valid), 64'd1);
    check_eq({tag, "_rdata"}, 64'(a_rsp_rdata), 64'(data));
    check_eq({tag, "_err"},   64'(a_rsp_err),   64'(err));
  endtask

  task automatic a_read_check(input string tag, input logic [15:0] addr, input logic [15:0] data,
                              input logic err);
    a_req(1'b0, addr, 16'h0, 2'b00);
    a_rsp_check(tag, data, err);
  endtask

  // Hold reset for one edge, release, and check busy/ready across the full sweep.
  task automatic a_reset_sweep(input string tag);
    a_rst_n = 1'b0;
    step();
    check_eq({tag, "_rst_valid"}, 64'(a_rsp_valid), 64'd0);
    check_eq({tag, "_rst_rdata"}, 64'(a_rsp_rdata), 64'd0);
    check_eq({tag, "_rst_ready"}, 64'(a_req_ready), 64'd0);
    check_eq({tag, "_rst_busy"},  64'(a_busy),      64'd1);
    a_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #0;
      check_eq({tag, "_sweep_busy"},  64'(a_busy),      64'd1);
      check_eq({tag, "_sweep_ready"}, 64'(a_req_ready), 64'd0);
      check_eq({tag, "_sweep_valid"}, 64'(a_rsp_valid), 64'd0);
      step();
    end
    check_eq({tag, "_done_busy"},  64'(a_busy),      64'd0);
    check_eq({tag, "_done_ready"}, 64'(a_req_ready), 64'd1);
  endtask

  initial begin
    a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_write = 1'b0;
    a_req_addr = '0; a_req_wdata = '0; a_req_wstrb = '0;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_write = 1'b0;
    b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    step();

    // Initial reset and sweep.
    a_reset_sweep("init");

    // Preload with all ones, then reset must clear every word.
    for (int i = 0; i < 8; i++) begin
      a_req(1'b1, 16'(i), 16'hFFFF, 2'b11);
    end
    a_read_check("preload", 16'd6, 16'hFFFF, 1'b0);
    a_reset_sweep("clr");
    for (int i = 0; i < 8; i++) begin
      a_read_check("clr_rd", 16'(i), 16'h0000, 1'b0);
    end

    // Full then upper-lane-only write.
    a_req(1'b1, 16'd3, 16'hABCD, 2'b11);
    a_rsp_check("wr_full", 16'h0000, 1'b0);
    a_req(1'b1, 16'd3, 16'h1200, 2'b10);
    a_rsp_check("wr_strb", 16'h0000, 1'b0);
    a_read_check("rd_strb", 16'd3, 16'h12CD, 1'b0);

    // Zero strobe is a no-op write that still responds without error.
    a_req(1'b1, 16'd3, 16'hFFFF, 2'b00);
    a_rsp_check("wr_nostrb", 16'h0000, 1'b0);
    a_read_check("rd_nostrb", 16'd3, 16'h12CD, 1'b0);

    // Back-to-back write then read of the same word.
    a_req(1'b1, 16'd5, 16'h0055, 2'b11);
    a_rsp_check("b2b_wr", 16'h0000, 1'b0);
    a_req(1'b0, 16'd5, 16'h0000, 2'b00);
    a_rsp_check("b2b_rd", 16'h0055, 1'b0);
    step();
    check_eq("idle_valid", 64'(a_rsp_valid), 64'd0);
    check_eq("idle_rdata", 64'(a_rsp_rdata), 64'd0);

    // Out of range: 0x0108 aliases index 0 and must not disturb it.
    a_req(1'b1, 16'd0, 16'h1234, 2'b11);
    a_read_check("oor_rd", 16'h0008, 16'h0000, 1'b1);
    a_req(1'b1, 16'h0108, 16'h00FF, 2'b11);
    a_rsp_check("oor_wr", 16'h0000, 1'b1);
    a_read_check("oor_keep", 16'd0, 16'h1234, 1'b0);
    a_read_check("top_rd", 16'hFFFF, 16'h0000, 1'b1);

    // Reset mid-sweep while a write request is held: ignored, sweep restarts.
    a_rst_n = 1'b0;
    step();
    a_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("mid_busy", 64'(a_busy), 64'd1);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'd2;
    a_req_wdata = 16'hFFFF; a_req_wstrb = 2'b11;
    a_rst_n = 1'b0;
    step();
    a_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #0;
      check_eq("mid_sweep_busy",  64'(a_busy),      64'd1);
      check_eq("mid_sweep_valid", 64'(a_rsp_valid), 64'd0);
      step();
    end
    a_req_valid = 1'b0;
    check_eq("mid_done_ready", 64'(a_req_ready), 64'd1);
    check_eq("mid_done_valid", 64'(a_rsp_valid), 64'd0);
    a_read_check("mid_rd2", 16'd2, 16'h0000, 1'b0);
    a_read_check("mid_rd0", 16'd0, 16'h0000, 1'b0);

    // Instance b: no clear on reset, 32-bit words.
    b_rst_n = 1'b1;
    #1;
    check_eq("b_busy",  64'(b_busy),      64'd0);
    check_eq("b_ready", 64'(b_req_ready), 64'd1);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 16'd15;
    b_req_wdata = 32'hDEADBEEF; b_req_wstrb = 4'hF;
    step();
    b_req_valid = 1'b0;
    check_eq("b_wr_valid", 64'(b_rsp_valid), 64'd1);
    check_eq("b_wr_err",   64'(b_rsp_err),   64'd0);
    b_rst_n = 1'b0;
    step();
    check_eq("b_rst_ready", 64'(b_req_ready), 64'd0);
    check_eq("b_rst_busy",  64'(b_busy),      64'd0);
    check_eq("b_rst_valid", 64'(b_rsp_valid), 64'd0);
    b_rst_n = 1'b1;
    #1;
    check_eq("b_rel_busy",  64'(b_busy),      64'd0);
    check_eq("b_rel_ready", 64'(b_req_ready), 64'd1);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 16'd15;
    step();
    b_req_valid = 1'b0;
    check_eq("b_rd_valid", 64'(b_rsp_valid), 64'd1);
    check_eq("b_rd_rdata", 64'(b_rsp_rdata), 64'h0000_0000_DEAD_BEEF);
    check_eq("b_rd_err",   64'(b_rsp_err),   64'd0);
    b_req_valid = 1'b1; b_req_addr = 16'd16;
    step();
    b_req_valid = 1'b0;
    check_eq("b_oor_err",   64'(b_rsp_err),   64'd1);
    check_eq("b_oor_rdata", 64'(b_rsp_rdata), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised, request/response data memory for the RISC datapath; successor to the fixed 8×16 combinational-read data RAM. Adds configurable width and depth, byte-lane write strobes, registered reads with a one-cycle response handshake, out-of-range address detection, and a hardware clear sweep after reset. Sits between the load/store stage and the memory array; one request per cycle, every accepted request gets exactly one response.

## Interface
- DATA_W, 16, word width in bits; multiple of 8
- ADDR_W, 16, width of the request address
- DEPTH, 8, number of words; power of two, 2..2^ADDR_W
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = contents untouched by reset

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_wstrb  in  DATA_W/8  byte-lane enables; bit i covers bits 8i+7..8i
- rsp_valid  out  1  response pulse, one cycle
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address out of range, qualified by rsp_valid
- busy  out  1  clear sweep in progress

## Operation
- States: CLEAR, IDLE. Reset forces CLEAR with sweep counter = 0 when CLEAR_ON_RESET=1, IDLE otherwise.
- CLEAR: each cycle writes all-zero to word[counter], counter increments; after word DEPTH-1 is written, next state IDLE. busy=1, req_ready=0 throughout.
- IDLE: req_ready=1, busy=0. Accept = req_valid & req_ready.
- Index = req_addr[log2(DEPTH)-1:0]. In range iff all req_addr bits above that index are 0.
- Accepted in-range write: for each lane with req_wstrb bit set, the lane is replaced by req_wdata; other lanes keep their value. req_wstrb=0 is a legal no-op write, still responded to with rsp_err=0.
- Accepted in-range read: word[index] registered into rsp_rdata.
- Out-of-range request (read or write): array unchanged, rsp_err=1, rsp_rdata=0.
- req_valid while req_ready=0: ignored, no response, no array change; requester must hold or retry.
- No backpressure on responses: consumer must take rsp_* in the rsp_valid cycle.

## Timing
- Reset (rst_n low at an edge): next cycle rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, busy=CLEAR_ON_RESET. A request in flight at reset produces no response.
- Reset asserted mid-sweep restarts the sweep at word 0; full sweep always takes DEPTH cycles after rst_n returns high.
- First accept possible in cycle DEPTH after rst_n release (CLEAR_ON_RESET=1) or cycle 0 (=0).
- Latency: request accepted at edge N → rsp_valid=1 for exactly the cycle after edge N; rsp_valid drops after one cycle unless another request was accepted at edge N+1.
- Throughput: one request per cycle in IDLE; back-to-back responses give continuous rsp_valid.
- Write at edge N then read of the same index at edge N+1 returns the new data (array updated at edge N); no forwarding path needed.
- rsp_rdata and rsp_err return to 0 in any cycle with rsp_valid=0.

## Test plan
- Reset/clear: preload array with 16'hFFFF, pulse rst_n low 1 cycle (CLEAR_ON_RESET=1) → busy=1 and req_ready=0 for 8 cycles, then reads of words 0..7 all return 16'h0000, rsp_err=0.
- Full and strobed write: write 16'hABCD to addr 3 with wstrb=2'b11, then 16'h1200 with wstrb=2'b10, read addr 3 → rsp_rdata=16'h12CD one cycle after the read accept.
- Back-to-back: accept write addr 5=16'h0055 at edge N, read addr 5 at N+1 → rsp_valid high two consecutive cycles, second carries 16'h0055.
- Out of range: read addr 16'h0008 and write 16'h00FF to addr 16'h0108 → both rsp_err=1, rsp_rdata=0; subsequent read of addr 0 returns its previous value unchanged.
- Reset mid-sweep: assert rst_n low at sweep cycle 4 → sweep restarts, busy stays high 8 further cycles after release, no rsp_valid generated.
- CLEAR_ON_RESET=0, DATA_W=32, DEPTH=16: write 32'hDEADBEEF to addr 15, reset → busy=0, req_ready=1 the cycle after release, read addr 15 returns 32'hDEADBEEF.
